led_breath_ctrl: RTL and testbench
==================================

# led_breath_ctrl

LED breathing controller for the 12 MHz demo board. It derives a 1 µs tick enable from `clk_int` and runs a PWM period counter. A five-state sequencer ramps the PWM duty up, holds it, ramps it down and holds it off, so the LED fades in and out continuously while `en` is high. It replaces ad-hoc divided clocks: everything runs on `clk_int`, and slow timing uses single-cycle enables only.

## Interface
- `CLK_PER_US`, 12: `clk_int` cycles per µs tick (≥2).
- `PWM_PERIOD_US`, 1000: PWM period in µs ticks; also the full-scale duty value.
- `DUTY_STEP`, 1: duty change per PWM period while ramping (1..PWM_PERIOD_US).
- `HOLD_PERIODS`, 200: PWM periods spent in each hold state (≥1).
- `LED_ACTIVE_LOW`, 1: 1 drives `led` low when lit.
- `DW`: localparam, `$clog2(PWM_PERIOD_US+1)`.

Ports:
- `clk_int`, in, 1: system clock, 12 MHz.
- `rst`, in, 1: reset, asynchronous, active-low.
- `en`, in, 1: level; 1 = breathe, 0 = fade out and stop.
- `led`, out, 1: registered PWM output.
- `duty`, out, DW: current duty in µs ticks, 0..PWM_PERIOD_US.
- `state`, out, 3: sequencer state encoding.
- `period_tick`, out, 1: one-cycle pulse on the last cycle of each PWM period.

## Operation
- Prescaler `cnt_us` counts 0..CLK_PER_US-1 and wraps. `us_tick` = (`cnt_us`==CLK_PER_US-1). It runs whenever out of reset, independent of `en`.
- `pwm_cnt` counts 0..PWM_PERIOD_US-1 and advances only on `us_tick`. `period_tick` = `us_tick` && `pwm_cnt`==PWM_PERIOD_US-1. It is combinational from registers.
- `led` is registered each cycle: lit = (`pwm_cnt` < `duty`). `duty`=0 means always dark; `duty`=PWM_PERIOD_US means always lit. Polarity is applied per `LED_ACTIVE_LOW`.
- `duty`, `state` and `hold_cnt` change only in `period_tick` cycles, so a new duty always starts at `pwm_cnt`=0 and no partial-period glitch is possible.
- FSM, all transitions evaluated on `period_tick`:
  - IDLE (0): `duty`=0. If `en`=1, go to RISE.
  - RISE (1): if `en`=0, go to FALL with duty unchanged. Else if `duty`+DUTY_STEP ≥ PWM_PERIOD_US, set `duty`=PWM_PERIOD_US, clear `hold_cnt` and go to HOLD_HI. Else `duty` += DUTY_STEP.
  - HOLD_HI (2): if `en`=0, go to FALL. Else if `hold_cnt`==HOLD_PERIODS-1, go to FALL. Else increment `hold_cnt`.
  - FALL (3): if `duty` ≤ DUTY_STEP, set `duty`=0, clear `hold_cnt`, and go to HOLD_LO (`en`=1) or IDLE (`en`=0). Else `duty` -= DUTY_STEP.
  - HOLD_LO (4): if `en`=0, go to IDLE. Else if `hold_cnt`==HOLD_PERIODS-1, go to RISE. Else increment `hold_cnt`.
- Width rules: the duty sum is computed in DW+1 bits, so there is no wrap. Saturation at the endpoints is mandatory. `duty` never exceeds PWM_PERIOD_US and never underflows.
- `en` is sampled only at `period_tick`. Pulses that do not span a `period_tick` are ignored.

## Timing
- Reset values: `cnt_us`=0, `pwm_cnt`=0, `duty`=0, `hold_cnt`=0, `state`=IDLE, `led`=dark (1 if LED_ACTIVE_LOW), `period_tick`=0.
- Reset mid-operation: all registers return to reset values immediately (asynchronous). Counting restarts from 0 on the first clock after `rst` releases.
- First `period_tick` after reset comes at cycle CLK_PER_US·PWM_PERIOD_US (1-based).
- `led` lags (`pwm_cnt`, `duty`) by one clock.
- Full rise with DUTY_STEP=1 takes PWM_PERIOD_US periods; with defaults that is 1 s rise, 0.2 s hold, 1 s fall, 0.2 s off.

## Structure
- Shared package `breath_pkg`: state enum (IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4) and `US_PER_MS`=1000.
- Sub-module `tick_gen #(CLK_PER_US)`: prescaler emitting `us_tick`. It is reusable for other demos in place of divided clocks.
- PWM counter, comparator and FSM live in `led_breath_ctrl`.

## Test plan
Bench parameters: CLK_PER_US=2, PWM_PERIOD_US=4, DUTY_STEP=1, HOLD_PERIODS=2, LED_ACTIVE_LOW=1. One period is 8 clocks.
- Reset with `en`=0, run 100 clocks: `led`=1 and `duty`=0 throughout; `period_tick` pulses at cycles 8, 16, 24, …
- `en`=1 from reset: `state` goes IDLE→RISE at the first tick. Duty then takes 1,2,3,4 at the following ticks, then HOLD_HI for 2 periods, then duty 3,2,1,0, then HOLD_LO for 2 periods, then RISE.
- With `duty`=2: `led` is low for exactly 4 clocks per period, starting one clock after `pwm_cnt` reaches 0.
- Drop `en` during HOLD_HI: next tick enters FALL, then duty 3,2,1,0, then IDLE, and `led` stays 1.
- Drop `en` while in HOLD_LO: IDLE at the next tick. An `en` pulse of 3 clocks between ticks causes no state change.
- Assert `rst` mid-RISE with `duty`=3: `led`=1, `duty`=0 and IDLE immediately. After release, the first `period_tick` comes at cycle 8.

Source files
------------

// File: rtl/breath_pkg.sv
// Shared definitions for the LED breathing controller and its helpers.
// Provides the sequencer state encoding, time-base constants and a width helper.
// Contents: state_t enum, US_PER_MS, cnt_width().
package breath_pkg;

   // Sequencer states; the encoding is visible on the top-level 'state' port.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RISE    = 3'd1,
      ST_HOLD_HI = 3'd2,
      ST_FALL    = 3'd3,
      ST_HOLD_LO = 3'd4
   } state_t;

   localparam int US_PER_MS = 1000;

   // Bits needed to hold 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      if (n <= 2) begin
         return 1;
      end
      return $clog2(n);
   endfunction

endpackage

// File: rtl/led_breath_ctrl_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle enable every CLK_PER_US clocks.
// Latency: us_tick is combinational from the counter; first pulse in cycle CLK_PER_US after reset.
// Backpressure: none; runs continuously whenever out of reset.
//
// Ports:
//   clk_int   in  1  system clock
//   rst       in  1  asynchronous active-low reset
//   o_us_tick out 1  high for one cycle when the counter sits at CLK_PER_US-1
module tick_gen
   import breath_pkg::*;
#(
   parameter int CLK_PER_US = 12
)(
   input  logic clk_int,
   input  logic rst,
   output logic o_us_tick
);

   localparam int            CW   = cnt_width(CLK_PER_US);
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

   logic [CW-1:0] r_cnt_us;
   logic          w_wrap;

   assign w_wrap    = (r_cnt_us == LAST);
   assign o_us_tick = w_wrap;

   always_ff @(posedge clk_int or negedge rst) begin
      if (!rst) begin
         r_cnt_us <= '0;
      end else if (w_wrap) begin
         r_cnt_us <= '0;
      end else begin
         r_cnt_us <= r_cnt_us + CW'(1);
      end
   end

endmodule

// File: rtl/led_breath_ctrl.sv
// led_breath_ctrl: PWM LED fader; duty ramps up, holds, ramps down, holds off while en is high.
// Latency: led lags pwm_cnt/duty by one clock; duty/state update only on the period_tick cycle.
// Backpressure: none; en is a level sampled once per PWM period.
//
// Ports:
//   clk_int     in  1   system clock
//   rst         in  1   asynchronous active-low reset
//   en          in  1   1 = keep breathing, 0 = fade out and park in IDLE
//   led         out 1   registered PWM output, polarity set by LED_ACTIVE_LOW
//   duty        out DW  current duty in us ticks, 0..PWM_PERIOD_US
//   state       out 3   sequencer state (breath_pkg::state_t encoding)
//   period_tick out 1   one-cycle pulse on the last cycle of each PWM period
module led_breath_ctrl
   import breath_pkg::*;
#(
   parameter int   CLK_PER_US     = 12,
   parameter int   PWM_PERIOD_US  = US_PER_MS,
   parameter int   DUTY_STEP      = 1,
   parameter int   HOLD_PERIODS   = 200,
   parameter bit   LED_ACTIVE_LOW = 1'b1,
   localparam int  DW             = $clog2(PWM_PERIOD_US + 1)
)(
   input  logic          clk_int,
   input  logic          rst,
   input  logic          en,
   output logic          led,
   output logic [DW-1:0] duty,
   output logic [2:0]    state,
   output logic          period_tick
);

   localparam int HW = cnt_width(HOLD_PERIODS);

   localparam logic [DW-1:0] PERIOD_LAST = DW'(PWM_PERIOD_US - 1);
   localparam logic [DW:0]   FULL_EXT    = (DW + 1)'(PWM_PERIOD_US);
   localparam logic [DW-1:0] FULL        = DW'(PWM_PERIOD_US);
   localparam logic [DW-1:0] STEP        = DW'(DUTY_STEP);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_PERIODS - 1);

   // ------------------------------------------------------------------
   // Time base
   // ------------------------------------------------------------------
   logic w_us_tick;

   tick_gen #(
      .CLK_PER_US (CLK_PER_US)
   ) u_tick_gen (
      .clk_int   (clk_int),
      .rst       (rst),
      .o_us_tick (w_us_tick)
   );

   logic [DW-1:0] r_pwm_cnt;
   logic          w_pwm_last;
   logic          w_period_tick;

   assign w_pwm_last    = (r_pwm_cnt == PERIOD_LAST);
   assign w_period_tick = w_us_tick && w_pwm_last;
   assign period_tick   = w_period_tick;

   always_ff @(posedge clk_int or negedge rst) begin
      if (!rst) begin
         r_pwm_cnt <= '0;
      end else if (w_us_tick) begin
         if (w_pwm_last) begin
            r_pwm_cnt <= '0;
         end else begin
            r_pwm_cnt <= r_pwm_cnt + DW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------
   state_t        r_state;
   state_t        w_state_nxt;
   logic [DW-1:0] r_duty;
   logic [DW-1:0] w_duty_nxt;
   logic [HW-1:0] r_hold_cnt;
   logic [HW-1:0] w_hold_nxt;

   // One extra bit so duty+step can never wrap before the saturation test.
   logic [DW:0]   w_duty_sum;
   logic          w_rise_sat;
   logic          w_fall_sat;
   logic          w_hold_done;

   assign w_duty_sum  = {1'b0, r_duty} + {1'b0, STEP};
   assign w_rise_sat  = (w_duty_sum >= FULL_EXT);
   assign w_fall_sat  = (r_duty <= STEP);
   assign w_hold_done = (r_hold_cnt == HOLD_LAST);

   always_ff @(posedge clk_int or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_duty     <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_duty     <= w_duty_nxt;
         r_hold_cnt <= w_hold_nxt;
      end
   end

   // Everything is gated by period_tick so a new duty always takes effect
   // at pwm_cnt = 0 and the LED never sees a truncated period.
   always_comb begin
      w_state_nxt = r_state;
      w_duty_nxt  = r_duty;
      w_hold_nxt  = r_hold_cnt;

      if (w_period_tick) begin
         case (r_state)
            ST_IDLE: begin
               w_duty_nxt = '0;
               if (en) begin
                  w_state_nxt = ST_RISE;
               end
            end

            ST_RISE: begin
               if (!en) begin
                  // Fade out from wherever the ramp got to.
                  w_state_nxt = ST_FALL;
               end else if (w_rise_sat) begin
                  w_duty_nxt  = FULL;
                  w_hold_nxt  = '0;
                  w_state_nxt = ST_HOLD_HI;
               end else begin
                  w_duty_nxt  = w_duty_sum[DW-1:0];
               end
            end

            ST_HOLD_HI: begin
               if (!en || w_hold_done) begin
                  w_state_nxt = ST_FALL;
               end else begin
                  w_hold_nxt  = r_hold_cnt + HW'(1);
               end
            end

            ST_FALL: begin
               if (w_fall_sat) begin
                  w_duty_nxt  = '0;
                  w_hold_nxt  = '0;
                  w_state_nxt = en ? ST_HOLD_LO : ST_IDLE;
               end else begin
                  w_duty_nxt  = r_duty - STEP;
               end
            end

            ST_HOLD_LO: begin
               if (!en) begin
                  w_state_nxt = ST_IDLE;
               end else if (w_hold_done) begin
                  w_state_nxt = ST_RISE;
               end else begin
                  w_hold_nxt  = r_hold_cnt + HW'(1);
               end
            end

            default: begin
               // Unreachable encodings recover to a dark, idle LED.
               w_state_nxt = ST_IDLE;
               w_duty_nxt  = '0;
               w_hold_nxt  = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // PWM output
   // ------------------------------------------------------------------
   // duty = 0 never lights (pwm_cnt < 0 is false); duty = full scale
   // always lights since pwm_cnt tops out at PWM_PERIOD_US-1.
   logic w_lit;
   logic r_led;

   assign w_lit = (r_pwm_cnt < r_duty);

   always_ff @(posedge clk_int or negedge rst) begin
      if (!rst) begin
         r_led <= LED_ACTIVE_LOW;
      end else begin
         r_led <= w_lit ^ LED_ACTIVE_LOW;
      end
   end

   assign led   = r_led;
   assign duty  = r_duty;
   assign state = r_state;

endmodule

// File: tb/tb_led_breath_ctrl.sv
module tb_led_breath_ctrl;
   import breath_pkg::*;

   logic       clk_int = 1'b0;
   logic       rst     = 1'b0;
   logic       en      = 1'b0;
   logic       led;
   logic [2:0] duty;
   logic [2:0] state;
   logic       period_tick;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk_int = ~clk_int;

   led_breath_ctrl #(
      .CLK_PER_US     (2),
      .PWM_PERIOD_US  (4),
      .DUTY_STEP      (1),
      .HOLD_PERIODS   (2),
      .LED_ACTIVE_LOW (1'b1)
   ) dut (
      .clk_int     (clk_int),
      .rst         (rst),
      .en          (en),
      .led         (led),
      .duty        (duty),
      .state       (state),
      .period_tick (period_tick)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, leaving the bench parked on a falling edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_int);
         @(negedge clk_int);
      end
   endtask

   // Run to the next period boundary: wait (bounded) for period_tick,
   // then cross the edge that applies it.
   task automatic next_period();
      for (int k = 0; k < 20; k++) begin
         if (period_tick) break;
         step(1);
      end
      chk("period_tick_seen", period_tick, 1);
      step(1);
   endtask

   task automatic chk_sd(input string tag, input int exp_st, input int exp_du);
      chk({tag, "_state"}, state, exp_st);
      chk({tag, "_duty"}, duty, exp_du);
   endtask

   task automatic do_reset(input logic en_val);
      rst = 1'b0;
      step(2);
      en  = en_val;
      rst = 1'b1;
   endtask

   // Expected sequence after IDLE->RISE with en held high.
   int exp_st_run[13] = '{1, 1, 1, 2, 2, 3, 3, 3, 3, 4, 4, 1, 1};
   int exp_du_run[13] = '{1, 2, 3, 4, 4, 4, 3, 2, 1, 0, 0, 0, 1};
   // LED samples across the duty=2 period, starting on the boundary edge.
   logic led_pat[8]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   // Fade-out after en drops in HOLD_HI.
   int exp_st_off[4]  = '{3, 3, 3, 0};
   int exp_du_off[4]  = '{3, 2, 1, 0};

   initial begin
      int cnt;

      // Reset values while rst is held low.
      step(1);
      chk("rst_led", led, 1);
      chk("rst_duty", duty, 0);
      chk("rst_state", state, 0);
      chk("rst_period_tick", period_tick, 0);
      rst = 1'b1;

      // en = 0 for 100 clocks: dark, duty 0, period_tick on cycles 8,16,...
      for (int k = 1; k <= 100; k++) begin
         step(1);
         chk("idle_led", led, 1);
         chk("idle_duty", duty, 0);
         chk("idle_period_tick", period_tick, ((k % 8) == 7) ? 1 : 0);
      end

      // Full breathing cycle with en = 1.
      do_reset(1'b1);
      next_period();
      chk_sd("run_b1", 1, 0);
      for (int i = 0; i < 13; i++) begin
         next_period();
         chk_sd("run", exp_st_run[i], exp_du_run[i]);
         if (i == 1) begin
            for (int j = 0; j < 8; j++) begin
               chk("pwm_duty2_led", led, led_pat[j]);
               if (j < 7) step(1);
            end
         end
      end

      // Drop en in HOLD_HI: fade out to IDLE, LED stays dark.
      do_reset(1'b1);
      repeat (5) next_period();
      chk_sd("hh_entry", 2, 4);
      step(3);
      en = 1'b0;
      next_period();
      chk_sd("hh_drop", 3, 4);
      for (int i = 0; i < 4; i++) begin
         next_period();
         chk_sd("hh_fade", exp_st_off[i], exp_du_off[i]);
      end
      for (int j = 0; j < 8; j++) begin
         chk("hh_dark_led", led, 1);
         if (j < 7) step(1);
      end
      next_period();
      chk_sd("hh_parked", 0, 0);

      // Drop en in HOLD_LO, then a short en pulse between ticks.
      do_reset(1'b1);
      repeat (11) next_period();
      chk_sd("hl_entry", 4, 0);
      step(2);
      en = 1'b0;
      next_period();
      chk_sd("hl_drop", 0, 0);
      step(2);
      en = 1'b1;
      step(3);
      en = 1'b0;
      next_period();
      chk_sd("hl_pulse_ignored", 0, 0);

      // Asynchronous reset mid-RISE with duty = 3.
      do_reset(1'b1);
      repeat (4) next_period();
      chk_sd("mid_rise", 1, 3);
      step(3);
      chk("mid_rise_led_lit", led, 0);
      rst = 1'b0;
      #1;
      chk("async_rst_led", led, 1);
      chk("async_rst_duty", duty, 0);
      chk("async_rst_state", state, 0);
      @(negedge clk_int);
      rst = 1'b1;
      cnt = 0;
      while (!period_tick && cnt < 20) begin
         step(1);
         cnt++;
      end
      chk("post_rst_first_tick_edges", cnt, 7);
      step(1);
      chk_sd("post_rst_rise", 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
